conv_enc_frame_ctrl: RTL and testbench
======================================

CONV_ENC_FRAME_CTRL -- requirements
Module: conv_enc_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 11, giving the number of information bits per frame (legal range 2..64).
REQ-002 SHALL have parameter TAIL_EN, default 1; when 1, TAIL = 2 zero flush bits are appended, and when 0, TAIL = 0.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Start  input  1  frame request; sampled only in IDLE.
REQ-006 Frame_In  input  FRAME_LEN  frame bits; Frame_In[0] is encoded first.
REQ-007 Busy  output  1  high in ENCODE, FLUSH and DONE.
REQ-008 Sym_Valid  output  1  one-cycle pulse per produced symbol.
REQ-009 Sym_Out  output  2  current symbol {Y1,Y0}.
REQ-010 PS_Out  output  2  encoder state used for the current symbol.
REQ-011 NS_Out  output  2  encoder state after the current symbol.
REQ-012 Encoded_Out  output  2*(FRAME_LEN+TAIL)  assembled frame; symbol k occupies bits [2k+1:2k].
REQ-013 Done  output  1  one-cycle pulse when Encoded_Out is complete.

Function
REQ-014 Encoder: rate 1/2, K=3, generators 7/5 octal.
  - State S = {s1,s0}; s1 is the most recent input.
  - Y1 = x^s1^s0; Y0 = x^s0.
  - Next state NS = {x,s1}.
REQ-015 FSM states: IDLE, ENCODE, FLUSH, DONE.
REQ-016 IDLE + Start=1 at edge E0:
  - capture Frame_In into a shift register;
  - S := 00; bit counter := 0; Encoded_Out := 0;
  - go to ENCODE.
REQ-017 ENCODE: each edge consumes one bit, x = the next captured bit in index order. On that edge it registers:
  - Sym_Out = Y; PS_Out = S; NS_Out = NS;
  - Sym_Valid = 1; writes Y into Encoded_Out slot k;
  - S := NS; k := k+1.
REQ-018 After FRAME_LEN symbols the FSM leaves ENCODE: to FLUSH if TAIL_EN=1, otherwise to DONE.
REQ-019 FLUSH: two edges with x = 0, producing slots FRAME_LEN and FRAME_LEN+1 exactly as in REQ-017. S is 00 on exit.
REQ-020 Symbols are registered on edges E1..E(FRAME_LEN+TAIL); the final such edge also moves the FSM to DONE.
REQ-021 DONE: Done = 1 for exactly one cycle; the next edge returns the FSM to IDLE.
REQ-022 Latency: Done is high in the cycle after edge E(FRAME_LEN+TAIL), i.e. 13 cycles after Start for the defaults.
REQ-023 Sym_Valid is 0 in IDLE and DONE. Sym_Out, PS_Out and NS_Out hold their last values when Sym_Valid = 0.
REQ-024 Start while Busy = 1 (including the DONE cycle) SHALL be ignored, with no queuing.
REQ-025 Start held high continuously starts a new frame on the first IDLE edge after each DONE, giving back-to-back frames with a period of FRAME_LEN+TAIL+2 cycles.
REQ-026 Frame_In changes after E0 SHALL NOT affect the frame in progress.
REQ-027 Encoded_Out holds the completed frame from DONE until the next accepted Start.
REQ-028 Bit counter width = ceil(log2(FRAME_LEN+3)); it never wraps within a frame.

Reset
REQ-029 Rst_n = 0 SHALL immediately, without waiting for a clock edge, force:
  - FSM = IDLE; S = 00; counter = 0;
  - Busy = Sym_Valid = Done = 0;
  - Sym_Out = PS_Out = NS_Out = 00; Encoded_Out = 0.
REQ-030 Reset asserted mid-frame aborts the frame: no Done is produced and no partial data is retained.
REQ-031 After Rst_n deasserts, the first Start is accepted on the first rising edge at which it is sampled high.

Verification (defaults: FRAME_LEN = 11, TAIL_EN = 1, Encoded_Out 26 bits)
REQ-032 Frame_In = 0, Start pulse -> 13 Sym_Valid pulses, all Sym_Out = 00; Done 13 cycles after Start; Encoded_Out = 0.
REQ-033 Frame_In = 11'h001 -> symbols 11,10,11 then 00s; PS/NS sequence 00→10, 10→01, 01→00; Encoded_Out = 26'h000003B.
REQ-034 Frame_In = 11'h7FF -> symbols 11,01,10×9, then tail 01,11; final NS = 00.
REQ-035 Start re-pulsed during ENCODE and again during the DONE cycle -> ignored; a single Done; Encoded_Out unchanged until the next IDLE Start.
REQ-036 Rst_n low at symbol 5 -> all outputs 0 asynchronously; no Done; a fresh frame afterwards matches REQ-033.
REQ-037 TAIL_EN = 0, Frame_In = 11'h001 -> 11 symbols; Done 11 cycles after Start; final NS_Out ≠ 00 is permitted.

Source files
------------

// File: rtl/conv_enc_frame_ctrl.sv
// Frame controller around a rate-1/2, K=3 (7,5 octal) convolutional encoder.
// Encodes one captured frame per Start, with optional zero tail, and assembles the coded frame.
module conv_enc_frame_ctrl #(
  parameter int FRAME_LEN = 11,
  parameter int TAIL_EN   = 1,
  localparam int TAIL     = (TAIL_EN != 0) ? 2 : 0,
  localparam int NSYM     = FRAME_LEN + TAIL,
  localparam int ENC_W    = 2 * NSYM,
  localparam int CNT_W    = $clog2(FRAME_LEN + 3)
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
  input  logic [FRAME_LEN-1:0] Frame_In,
  output logic                 Busy,
  output logic                 Sym_Valid,
  output logic [1:0]           Sym_Out,
  output logic [1:0]           PS_Out,
  output logic [1:0]           NS_Out,
  output logic [ENC_W-1:0]     Encoded_Out,
  output logic                 Done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Encoder output {Y1,Y0} for input x and state {s1,s0}.
  function automatic logic [1:0] conv_sym(input logic x, input logic [1:0] s);
    conv_sym = {x ^ s[1] ^ s[0], x ^ s[0]};
  endfunction

  // Register state after shifting x in; s1 always holds the newest bit.
  function automatic logic [1:0] conv_next(input logic x, input logic [1:0] s);
    conv_next = {x, s[1]};
  endfunction

  state_t               state_r;
  logic [FRAME_LEN-1:0] shreg_r;
  logic [1:0]           st_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [ENC_W-1:0]     enc_r;
  logic                 busy_r;
  logic                 sym_valid_r;
  logic                 done_r;
  logic [1:0]           sym_r;
  logic [1:0]           ps_r;
  logic [1:0]           ns_r;

  logic                 x_s;
  logic [1:0]           y_s;
  logic [1:0]           ns_s;
  logic                 last_data_s;
  logic                 last_sym_s;

  // Current encoder input, symbol and end-of-phase decodes.
  always_comb begin
    x_s = 1'b0;
    if (state_r == ST_ENCODE) begin
      x_s = shreg_r[0];
    end else begin
      x_s = 1'b0;
    end
    y_s         = conv_sym(x_s, st_r);
    ns_s        = conv_next(x_s, st_r);
    last_data_s = (cnt_r == CNT_W'(FRAME_LEN - 1));
    last_sym_s  = (cnt_r == CNT_W'(NSYM - 1));
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= ST_IDLE;
      shreg_r     <= '0;
      st_r        <= 2'b00;
      cnt_r       <= '0;
      enc_r       <= '0;
      busy_r      <= 1'b0;
      sym_valid_r <= 1'b0;
      done_r      <= 1'b0;
      sym_r       <= 2'b00;
      ps_r        <= 2'b00;
      ns_r        <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sym_valid_r <= 1'b0;
          done_r      <= 1'b0;
          if (Start) begin
            shreg_r <= Frame_In;
            st_r    <= 2'b00;
            cnt_r   <= '0;
            enc_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_ENCODE;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_ENCODE, ST_FLUSH: begin
          sym_r       <= y_s;
          ps_r        <= st_r;
          ns_r        <= ns_s;
          sym_valid_r <= 1'b1;
          st_r        <= ns_s;
          cnt_r       <= cnt_r + CNT_W'(1);
          shreg_r     <= {1'b0, shreg_r[FRAME_LEN-1:1]};
          for (int i = 0; i < NSYM; i++) begin
            if (cnt_r == CNT_W'(i)) begin
              enc_r[2*i +: 2] <= y_s;
            end
          end
          // Data phase ends after FRAME_LEN symbols; tail phase after all NSYM.
          if ((state_r == ST_ENCODE) && last_data_s && (TAIL != 0)) begin
            state_r <= ST_FLUSH;
            done_r  <= 1'b0;
          end else if (((state_r == ST_ENCODE) && last_data_s) || last_sym_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          sym_valid_r <= 1'b0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          sym_valid_r <= 1'b0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy        = busy_r;
  assign Sym_Valid   = sym_valid_r;
  assign Sym_Out     = sym_r;
  assign PS_Out      = ps_r;
  assign NS_Out      = ns_r;
  assign Encoded_Out = enc_r;
  assign Done        = done_r;

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Bench for conv_enc_frame_ctrl: table vectors, scoreboard of symbols/frames,
// and directed sequences for Start masking, back-to-back frames and mid-frame reset.
module tb_conv_enc_frame_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [10:0] Frame_In = 11'h000;

  logic        Busy, Sym_Valid, Done;
  logic [1:0]  Sym_Out, PS_Out, NS_Out;
  logic [25:0] Encoded_Out;

  logic        busy0, sym_valid0, done0;
  logic [1:0]  sym0, ps0, ns0;
  logic [21:0] enc0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] sym;
    logic [1:0] ps;
    logic [1:0] ns;
  } sym_t;

  typedef struct {
    logic [10:0] f;
    logic [25:0] enc;
    logic [1:0]  ns;
  } vec_t;

  sym_t        sym_q[$];
  logic [25:0] enc_q[$];
  sym_t        mon_e;
  logic [25:0] mon_enc;

  conv_enc_frame_ctrl #(.FRAME_LEN(11), .TAIL_EN(1)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Frame_In(Frame_In),
    .Busy(Busy), .Sym_Valid(Sym_Valid), .Sym_Out(Sym_Out), .PS_Out(PS_Out),
    .NS_Out(NS_Out), .Encoded_Out(Encoded_Out), .Done(Done)
  );

  conv_enc_frame_ctrl #(.FRAME_LEN(11), .TAIL_EN(0)) u_dut_notail (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Frame_In(Frame_In),
    .Busy(busy0), .Sym_Valid(sym_valid0), .Sym_Out(sym0), .PS_Out(ps0),
    .NS_Out(ns0), .Encoded_Out(enc0), .Done(done0)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] model_enc(input logic [10:0] f);
    logic [1:0] s;
    logic       x;
    logic [25:0] e;
    s = 2'b00;
    e = 26'h0;
    for (int i = 0; i < 13; i++) begin
      x = (i < 11) ? f[i] : 1'b0;
      e[2*i +: 2] = {x ^ s[1] ^ s[0], x ^ s[0]};
      s = {x, s[1]};
    end
    return e;
  endfunction

  task automatic push_syms(input logic [10:0] f);
    logic [1:0] s;
    logic [1:0] ns;
    logic       x;
    s = 2'b00;
    for (int i = 0; i < 13; i++) begin
      x  = (i < 11) ? f[i] : 1'b0;
      ns = {x, s[1]};
      sym_q.push_back({x ^ s[1] ^ s[0], x ^ s[0], s, ns});
      s  = ns;
    end
  endtask

  // Scoreboard: compare every produced symbol and every completed frame.
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (Sym_Valid) begin
        if (sym_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_sym: got sym=%0h with none pending", Sym_Out);
        end else begin
          mon_e = sym_q.pop_front();
          chk("sym_ps_ns", {58'h0, Sym_Out, PS_Out, NS_Out}, {58'h0, mon_e});
        end
      end
      if (Done) begin
        if (enc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_done: got Done with Encoded_Out=%0h, none pending", Encoded_Out);
        end else begin
          mon_enc = enc_q.pop_front();
          chk("encoded_out", {38'h0, Encoded_Out}, {38'h0, mon_enc});
        end
      end
    end
  end

  task automatic do_frame(input logic [10:0] f, input logic [25:0] enc, input logic [1:0] ns);
    int n, nm, n0;
    push_syms(f);
    enc_q.push_back(enc);
    @(negedge Clk);
    Frame_In = f;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    Start    = 1'b0;
    Frame_In = ~f;
    chk("busy_after_start", {63'h0, Busy}, 64'd1);
    n  = 0;
    nm = -1;
    n0 = -1;
    while ((nm < 0 || n0 < 0) && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
      if (done0 && n0 < 0) begin
        n0 = n;
        chk("notail_encoded", {42'h0, enc0}, {42'h0, enc[21:0]});
      end
      if (Done && nm < 0) begin
        nm = n;
        chk("final_ns", {62'h0, NS_Out}, {62'h0, ns});
      end
    end
    chk("done_latency", 64'(nm), 64'd13);
    chk("notail_latency", 64'(n0), 64'd11);
    @(posedge Clk);
    #1;
    chk("busy_back_idle", {63'h0, Busy}, 64'd0);
    chk("sym_q_drained", 64'(sym_q.size()), 64'd0);
  endtask

  initial begin
    vec_t tbl[4];
    int   n;
    int   done_cnt;
    logic [10:0] rf;

    tbl[0] = '{11'h000, 26'h0000000, 2'b00};
    tbl[1] = '{11'h001, 26'h000003B, 2'b00};
    tbl[2] = '{11'h7FF, 26'h36AAAA7, 2'b00};
    tbl[3] = '{11'h002, 26'h00000EC, 2'b00};

    #13;
    chk("reset_outputs", {29'h0, Busy, Sym_Valid, Done, Sym_Out, PS_Out, NS_Out, Encoded_Out}, 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_frame(tbl[i].f, tbl[i].enc, tbl[i].ns);
    end

    for (int i = 0; i < 3; i++) begin
      rf = 11'($urandom);
      do_frame(rf, model_enc(rf), 2'b00);
    end

    // Start pulses during ENCODE and during DONE must be ignored.
    push_syms(11'h001);
    enc_q.push_back(26'h000003B);
    @(negedge Clk);
    Frame_In = 11'h001;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    n = 0;
    while (!Done && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("ignore_done_seen", {63'h0, Done}, 64'd1);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    done_cnt = 0;
    repeat (20) begin
      @(posedge Clk);
      #1;
      if (Done) done_cnt++;
    end
    chk("ignore_extra_done", 64'(done_cnt), 64'd0);
    chk("ignore_enc_hold", {38'h0, Encoded_Out}, 64'h3B);
    chk("ignore_sym_q", 64'(sym_q.size()), 64'd0);

    // Start held high: back-to-back frames every FRAME_LEN+TAIL+2 cycles.
    push_syms(11'h001);
    push_syms(11'h001);
    enc_q.push_back(26'h000003B);
    enc_q.push_back(26'h000003B);
    @(negedge Clk);
    Frame_In = 11'h001;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    n = 0;
    while (!Done && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("b2b_first_latency", 64'(n), 64'd13);
    n = 0;
    do begin
      @(posedge Clk);
      #1;
      n++;
    end while (!Done && n < 40);
    chk("b2b_period", 64'(n), 64'd15);
    Start = 1'b0;
    repeat (20) @(posedge Clk);
    #1;
    chk("b2b_queues_drained", 64'(sym_q.size() + enc_q.size()), 64'd0);

    // Reset in the middle of a frame, then a fresh frame right after release.
    push_syms(11'h001);
    enc_q.push_back(26'h000003B);
    @(negedge Clk);
    Frame_In = 11'h001;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {29'h0, Busy, Sym_Valid, Done, Sym_Out, PS_Out, NS_Out, Encoded_Out}, 64'd0);
    sym_q.delete();
    enc_q.delete();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("abort_no_partial", {38'h0, Encoded_Out}, 64'd0);
    do_frame(11'h001, 26'h000003B, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
